// File: rtl/cordic_sched_pkg.sv
// Shared types and constants for the CORDIC cosine scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_sched_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } sched_state_t;

    // Biased exponent of 1.0; anything at or above is outside the core's range
    localparam logic [7:0] EXP_LIMIT = 8'd127;

    // Number of enabled core cycles per job
    localparam int ITER_DEFAULT = 16;

    // cos is even, so the core only ever sees |x|
    function automatic logic [31:0] clear_sign(input logic [31:0] x);
        return {1'b0, x[30:0]};
    endfunction

endpackage

// File: rtl/cordic_cos_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last winner.
// Latency: grant is combinational; pointer updates on the clock after an advance.
// Backpressure: grant only while i_grant_en is high; no grant without a request.
module rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             i_clock,
    input  logic             i_aclr_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_grant_en,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_grant
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_win_idx;
    logic             w_found;

    // Walk the requesters starting at pointer+1, wrapping at N_REQ-1, first hit wins
    always_comb begin
        o_grant   = '0;
        w_found   = 1'b0;
        w_idx     = r_ptr;
        w_win_idx = r_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
            if (i_grant_en && !w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
                w_win_idx      = w_idx;
            end
        end
    end

    // Remember the last winner; reset value makes requester 0 first in line
    always_ff @(posedge i_clock or negedge i_aclr_n) begin
        if (!i_aclr_n) begin
            r_ptr <= PTR_LAST;
        end else if (i_advance && w_found) begin
            r_ptr <= w_win_idx;
        end
    end

endmodule

// File: rtl/cordic_cos_scheduler.sv
// Shares one iterative CORDIC cosine core between N_REQ requesters.
// Latency: ITER+3 cycles handshake-to-resp_valid via core, 1 cycle for out-of-range bypass.
// Backpressure: one job in flight; req_ready only in IDLE, response held until resp_ready.
module cordic_cos_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1,
    parameter int ITER  = ITER_DEFAULT
) (
    input  logic                clock,
    input  logic                aclr_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_data,
    output logic [ID_W-1:0]     resp_id,
    output logic                resp_err,
    output logic                core_aclr,
    output logic                core_clk_en,
    output logic [31:0]         core_dataa,
    input  logic [31:0]         core_result
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    sched_state_t r_state;
    sched_state_t w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic             r_resp_valid;
    logic [31:0]      r_resp_data;
    logic [ID_W-1:0]  r_resp_id;
    logic             r_resp_err;
    logic             r_core_aclr;
    logic             r_core_clk_en;
    logic [31:0]      r_core_dataa;

    logic [N_REQ-1:0] w_grant;
    logic             w_grant_en;
    logic             w_hs;
    logic [ID_W-1:0]  w_grant_id;
    logic [31:0]      w_grant_data;
    logic [31:0]      w_op;
    logic             w_bypass;
    logic             w_core_active;
    logic [31:0]      w_dataa_src;

    // Grants are only offered in IDLE and never while reset is asserted
    assign w_grant_en = (r_state == S_IDLE) && aclr_n;

    rr_arbiter #(
        .N_REQ      (N_REQ)
    ) u_arb (
        .i_clock    (clock),
        .i_aclr_n   (aclr_n),
        .i_req      (req_valid),
        .i_grant_en (w_grant_en),
        .i_advance  (w_hs),
        .o_grant    (w_grant)
    );

    assign w_hs      = |w_grant;
    assign req_ready = w_grant;

    // Encode the one-hot grant and select the winning operand
    always_comb begin
        w_grant_id   = '0;
        w_grant_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_id   = ID_W'(i);
                w_grant_data = req_data[32*i +: 32];
            end
        end
    end

    // |x| >= 1.0, Inf and NaN never reach the core; zero and denormals do
    assign w_op     = clear_sign(w_grant_data);
    assign w_bypass = (w_op[30:23] >= EXP_LIMIT);

    // State register
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: bypass jumps straight to RESP, core jobs walk LOAD/RUN/CAPTURE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_next_state = w_bypass ? S_RESP : S_LOAD;
                end
            end
            S_LOAD:    w_next_state = S_RUN;
            S_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: w_next_state = S_RESP;
            S_RESP: begin
                // resp_valid is high for the whole of RESP
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Operand is presented from LOAD through CAPTURE; taken fresh at the handshake
    assign w_core_active = (w_next_state == S_LOAD) || (w_next_state == S_RUN) ||
                           (w_next_state == S_CAPTURE);
    assign w_dataa_src   = (r_state == S_IDLE) ? w_op : r_core_dataa;

    // Core controls registered from the next state so they line up with it
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_core_aclr   <= 1'b1;
            r_core_clk_en <= 1'b0;
            r_core_dataa  <= '0;
            r_cnt         <= '0;
        end else begin
            r_core_aclr   <= (w_next_state == S_LOAD);
            r_core_clk_en <= (w_next_state == S_RUN);
            r_core_dataa  <= w_core_active ? w_dataa_src : '0;
            r_cnt         <= ((r_state == S_RUN) && (w_next_state == S_RUN)) ?
                             r_cnt + 1'b1 : '0;
        end
    end

    // Response fields: tag at handshake, result at CAPTURE, frozen throughout RESP
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= (w_next_state == S_RESP);
            if (w_hs) begin
                r_resp_id   <= w_grant_id;
                r_resp_err  <= w_bypass;
                r_resp_data <= '0;
            end else if (r_state == S_CAPTURE) begin
                r_resp_data <= core_result;
            end
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_id     = r_resp_id;
    assign resp_err    = r_resp_err;
    assign core_aclr   = r_core_aclr;
    assign core_clk_en = r_core_clk_en;
    assign core_dataa  = r_core_dataa;

endmodule

// File: tb/tb_cordic_cos_scheduler.sv
// Bench for cordic_cos_scheduler with a behavioural CORDIC core and a scoreboard.
// Latency: checks ITER+3 core path and 1-cycle bypass.
// Backpressure: exercises resp_ready low with a competing request pending.
module tb_cordic_cos_scheduler;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;
    localparam int ITER  = 16;

    logic                clock = 1'b0;
    logic                aclr_n;
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_data;
    logic [ID_W-1:0]     resp_id;
    logic                resp_err;
    logic                core_aclr;
    logic                core_clk_en;
    logic [31:0]         core_dataa;
    logic [31:0]         core_result;

    always #5 clock = ~clock;

    cordic_cos_scheduler #(
        .N_REQ       (N_REQ),
        .ID_W        (ID_W),
        .ITER        (ITER)
    ) dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .resp_err    (resp_err),
        .core_aclr   (core_aclr),
        .core_clk_en (core_clk_en),
        .core_dataa  (core_dataa),
        .core_result (core_result)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference cosine for the operands used here; others get a recognisable tag
    function automatic logic [31:0] cos_ref(input logic [31:0] op);
        if (op == 32'h3F00_0000)  return 32'h3F60_A8B9;
        if (op[30:0] == 31'd0)    return 32'h3F80_0000;
        return op ^ 32'h5A5A_5A5A;
    endfunction

    // Core model: result is only meaningful after exactly ITER enables since load
    logic [31:0] c_op = '0;
    int          c_cnt = 0;
    always @(posedge clock) begin
        if (core_aclr) begin
            c_op  <= core_dataa;
            c_cnt <= 0;
        end else if (core_clk_en) begin
            c_cnt <= c_cnt + 1;
        end
    end
    assign core_result = (c_cnt == ITER) ? cos_ref(c_op) : 32'hDEAD_BEEF;

    function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
        int idx;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (ptr + k) % N_REQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] data;
        logic [31:0] op;
        int          hs_cyc;
    } exp_t;

    exp_t sb[$];
    int   glog_id[$];
    int   glog_cyc[$];
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    int          m_ptr = N_REQ - 1;
    bit          m_busy = 0;
    bit          m_free_next = 0;
    int          en_cnt = 0;
    int          aclr_cnt = 0;
    bit          prev_rv = 0;
    bit          hold = 0;
    logic [31:0] snap_d;
    logic        snap_e;
    logic [ID_W-1:0] snap_i;

    // Scheduler model and scoreboard, sampled on the falling edge
    always @(negedge clock) begin
        int               pick;
        logic [N_REQ-1:0] exp_rdy;
        exp_t             e;
        logic [31:0]      d;
        if (!aclr_n) begin
            m_ptr       = N_REQ - 1;
            m_busy      = 0;
            m_free_next = 0;
            sb.delete();
            prev_rv     = 0;
            hold        = 0;
            en_cnt      = 0;
            aclr_cnt    = 0;
        end else begin
            if (m_free_next) begin
                m_busy      = 0;
                m_free_next = 0;
            end
            en_cnt   += int'(core_clk_en);
            aclr_cnt += int'(core_aclr);
            if (m_busy && core_aclr && sb.size() > 0)
                check_eq("core_dataa", core_dataa, sb[0].op);
            exp_rdy = '0;
            pick    = -1;
            if (!m_busy) begin
                pick = rr_pick(req_valid, m_ptr);
                if (pick >= 0) exp_rdy[pick] = 1'b1;
                check_eq("idle_dataa", core_dataa, 32'h0);
            end
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (pick >= 0) begin
                d        = req_data[32*pick +: 32];
                e.id     = pick;
                e.op     = {1'b0, d[30:0]};
                e.err    = (e.op[30:23] >= 8'd127);
                e.data   = e.err ? 32'h0 : cos_ref(e.op);
                e.hs_cyc = cyc;
                sb.push_back(e);
                glog_id.push_back(pick);
                glog_cyc.push_back(cyc);
                m_busy   = 1;
                m_ptr    = pick;
                en_cnt   = 0;
                aclr_cnt = 0;
            end
            if (resp_valid && !prev_rv && sb.size() > 0)
                check_eq("resp_latency", 32'(cyc - sb[0].hs_cyc),
                         sb[0].err ? 32'd1 : 32'(ITER + 3));
            if (resp_valid && hold) begin
                check_eq("hold_data", resp_data, snap_d);
                check_eq("hold_id", 32'(resp_id), 32'(snap_i));
                check_eq("hold_err", 32'(resp_err), 32'(snap_e));
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("resp_unexpected", 32'(resp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    check_eq("resp_data", resp_data, e.data);
                    check_eq("resp_id", 32'(resp_id), 32'(e.id));
                    check_eq("resp_err", 32'(resp_err), 32'(e.err));
                    check_eq("clk_en_cycles", 32'(en_cnt), e.err ? 32'd0 : 32'(ITER));
                    check_eq("aclr_pulses", 32'(aclr_cnt), e.err ? 32'd0 : 32'd1);
                end
                m_free_next = 1;
            end
            prev_rv = resp_valid;
            hold    = resp_valid && !resp_ready;
            snap_d  = resp_data;
            snap_i  = resp_id;
            snap_e  = resp_err;
        end
    end

    task automatic raise_req(input int i, input logic [31:0] d);
        req_data[32*i +: 32] = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_grant(input int i);
        bit got;
        got = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clock);
            if (req_ready[i]) begin
                got = 1;
                break;
            end
        end
        check_eq("grant_seen", 32'(got), 32'd1);
        @(posedge clock);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400; t++) begin
            @(posedge clock);
            #1;
            if (sb.size() == 0 && !resp_valid) break;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int n0;
        aclr_n     = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = 1'b1;

        // Reset values, with a request pending to confirm req_ready stays low
        req_valid[0] = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_data", resp_data, 32'h0);
        check_eq("rst_resp_id", 32'(resp_id), 32'h0);
        check_eq("rst_resp_err", 32'(resp_err), 32'h0);
        check_eq("rst_core_clk_en", 32'(core_clk_en), 32'h0);
        check_eq("rst_core_dataa", core_dataa, 32'h0);
        check_eq("rst_core_aclr", 32'(core_aclr), 32'h1);
        req_valid = '0;
        @(posedge clock);
        #1;
        aclr_n = 1'b1;

        // Single job, sign fold, then two bypass operands
        raise_req(0, 32'h3F00_0000); wait_grant(0); wait_drain();
        raise_req(1, 32'hBF00_0000); wait_grant(1); wait_drain();
        raise_req(0, 32'h3FC0_0000); wait_grant(0); wait_drain();
        raise_req(1, 32'h7FC0_0000); wait_grant(1); wait_drain();

        // Fairness: both requesters hold valid, ready tied high
        n0 = glog_id.size();
        raise_req(0, 32'h3E80_0000);
        raise_req(1, 32'h8000_0000);
        got = 0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clock);
            #1;
            if (glog_id.size() >= n0 + 4) begin
                got = 1;
                break;
            end
        end
        req_valid = '0;
        check_eq("fair_jobs_seen", 32'(got), 32'd1);
        if (got) begin
            for (int j = 0; j < 4; j++)
                check_eq("fair_order", 32'(glog_id[n0 + j]), 32'(j % 2));
            for (int j = 1; j < 4; j++)
                check_eq("fair_spacing", 32'(glog_cyc[n0 + j] - glog_cyc[n0 + j - 1]),
                         32'(ITER + 4));
        end
        wait_drain();

        // Backpressure: 5 cycles of resp_ready low while requester 1 waits
        resp_ready = 1'b0;
        raise_req(0, 32'h3F00_0000);
        wait_grant(0);
        got = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (resp_valid) begin
                got = 1;
                break;
            end
        end
        check_eq("bp_resp_seen", 32'(got), 32'd1);
        raise_req(1, 32'h3E00_0000);
        repeat (5) @(posedge clock);
        #1;
        resp_ready = 1'b1;
        wait_grant(1);
        wait_drain();

        // Reset at RUN count 7 of a requester-0 job
        raise_req(0, 32'h3F00_0000);
        wait_grant(0);
        repeat (8) @(posedge clock);
        #2;
        check_eq("pre_rst_clk_en", 32'(core_clk_en), 32'h1);
        aclr_n = 1'b0;
        #1;
        check_eq("midrst_core_aclr", 32'(core_aclr), 32'h1);
        check_eq("midrst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("midrst_clk_en", 32'(core_clk_en), 32'h0);
        check_eq("midrst_dataa", core_dataa, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        aclr_n = 1'b1;
        raise_req(0, 32'h0000_0000);
        raise_req(1, 32'h3F00_0000);
        got = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (|req_ready) begin
                got = 1;
                break;
            end
        end
        check_eq("post_rst_first_grant", 32'(req_ready), 32'h1);
        if (got) begin
            @(posedge clock);
            #1;
            req_valid[0] = 1'b0;
        end
        wait_grant(1);
        wait_drain();
        repeat (30) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
